// File: rtl/ram_sp_rr_arb_if.sv
// ram_sp_rr_arb bus: requester command/response lanes plus the RAM port.
// The arbiter takes the slave side; the client/RAM harness takes master.
interface ram_sp_rr_arb_if #(
  parameter int NUM_REQ        = 2,
  parameter int WORD_BIT_WIDTH = 32,
  parameter int DEPTH          = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = WORD_BIT_WIDTH / 8;

  logic [NUM_REQ-1:0]                     i_req_valid;
  logic [NUM_REQ-1:0]                     o_req_ready;
  logic [NUM_REQ-1:0]                     i_req_we;
  logic [NUM_REQ-1:0][AW-1:0]             i_req_word_addr;
  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0][BW-1:0]             i_req_byte_en;
  logic [NUM_REQ-1:0]                     o_rsp_valid;
  logic [WORD_BIT_WIDTH-1:0]              o_rsp_data;
  logic                                   o_ram_we;
  logic [AW-1:0]                          o_ram_word_addr;
  logic [WORD_BIT_WIDTH-1:0]              o_ram_data;
  logic [BW-1:0]                          o_ram_wr_byte_en;
  logic [WORD_BIT_WIDTH-1:0]              i_ram_data;
  logic                                   o_busy;

  modport slave (
    input  i_req_valid, i_req_we, i_req_word_addr,
    input  i_req_data, i_req_byte_en, i_ram_data,
    output o_req_ready, o_rsp_valid, o_rsp_data,
    output o_ram_we, o_ram_word_addr, o_ram_data,
    output o_ram_wr_byte_en, o_busy
  );

  modport master (
    output i_req_valid, i_req_we, i_req_word_addr,
    output i_req_data, i_req_byte_en, i_ram_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data,
    input  o_ram_we, o_ram_word_addr, o_ram_data,
    input  o_ram_wr_byte_en, o_busy
  );
endinterface

// File: rtl/ram_sp_rr_arb.sv
// Round-robin arbiter sharing one single-port block RAM among requesters.
// Registers the winning command, tags reads, routes read data back.
module ram_sp_rr_arb #(
  parameter int NUM_REQ          = 2,
  parameter int WORD_BIT_WIDTH   = 32,
  parameter int DEPTH            = 8,
  parameter int RAM_READ_LATENCY = 1
) (
  input logic          i_clk,
  input logic          i_arst_n,
  ram_sp_rr_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = WORD_BIT_WIDTH / 8;
  localparam int PW = $clog2(NUM_REQ);
  localparam int TD = RAM_READ_LATENCY + 1;

  if (RAM_READ_LATENCY != 1 && RAM_READ_LATENCY != 2) begin : g_bad_lat
    $error("RAM_READ_LATENCY must be 1 or 2");
  end

  logic [PW-1:0]             ptr_q, ptr_d;
  logic [NUM_REQ-1:0]        grant;
  logic [PW-1:0]             win;
  logic                      xfer;
  logic                      ram_we_q, ram_we_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [WORD_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]             be_q, be_d;
  logic [TD-1:0]             tvld_q, tvld_d;
  logic [TD-1:0][PW-1:0]     tidx_q, tidx_d;
  logic [NUM_REQ-1:0]        rsp_vld_q, rsp_vld_d;
  logic [WORD_BIT_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Pick first valid requester after the pointer, wrapping around.
  always_comb begin : arb
    int j;
    logic [PW-1:0] idx;
    grant = '0;
    win   = '0;
    xfer  = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = PW'(j);
      if (!xfer && bus.i_req_valid[idx]) begin
        xfer       = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Next pointer, command register, tag pipeline and response.
  always_comb begin
    logic wr;
    wr         = xfer & bus.i_req_we[win];
    ptr_d      = xfer ? win : ptr_q;
    ram_we_d   = wr;
    addr_d     = xfer ? bus.i_req_word_addr[win] : addr_q;
    wdata_d    = wr ? bus.i_req_data[win] : wdata_q;
    be_d       = wr ? bus.i_req_byte_en[win] : '0;
    tvld_d     = {tvld_q[TD-2:0], xfer & ~bus.i_req_we[win]};
    tidx_d     = {tidx_q[TD-2:0], win};
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (tvld_q[TD-1]) begin
      rsp_vld_d  = NUM_REQ'(1) << tidx_q[TD-1];
      rsp_data_d = bus.i_ram_data;
    end
  end

  // State registers; reset favours requester 0 and drops in-flight reads.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q      <= PW'(NUM_REQ - 1);
      ram_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      tvld_q     <= '0;
      tidx_q     <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ram_we_q   <= ram_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      tvld_q     <= tvld_d;
      tidx_q     <= tidx_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.o_req_ready      = grant;
  assign bus.o_ram_we         = ram_we_q;
  assign bus.o_ram_word_addr  = addr_q;
  assign bus.o_ram_data       = wdata_q;
  assign bus.o_ram_wr_byte_en = be_q;
  assign bus.o_rsp_valid      = rsp_vld_q;
  assign bus.o_rsp_data       = rsp_data_q;
  assign bus.o_busy           = |tvld_q;
endmodule

// File: tb/tb_ram_sp_rr_arb.sv
// Bench for ram_sp_rr_arb: behavioural write-first RAM, directed stimulus,
// scoreboard queue of expected read responses checked by a monitor.
module tb_ram_sp_rr_arb;
  localparam int N   = 2;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int LAT = 1;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ram_sp_rr_arb_if #(.NUM_REQ(N), .WORD_BIT_WIDTH(W), .DEPTH(D)) bus();

  ram_sp_rr_arb #(
    .NUM_REQ(N), .WORD_BIT_WIDTH(W), .DEPTH(D), .RAM_READ_LATENCY(LAT)
  ) dut (
    .i_clk(clk),
    .i_arst_n(arst_n),
    .bus(bus)
  );

  logic [W-1:0] mem [D];
  logic [W-1:0] rd1 = '0;
  logic [W-1:0] rd2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port write-first RAM with byte enables.
  always @(posedge clk) begin
    logic [W-1:0] nw;
    nw = mem[bus.o_ram_word_addr];
    for (int b = 0; b < W/8; b++)
      if (bus.o_ram_we && bus.o_ram_wr_byte_en[b])
        nw[b*8 +: 8] = bus.o_ram_data[b*8 +: 8];
    if (bus.o_ram_we) mem[bus.o_ram_word_addr] <= nw;
    rd1 <= nw;
    rd2 <= rd1;
  end

  assign bus.i_ram_data = (LAT == 1) ? rd1 : rd2;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: grant one-hotness every cycle, responses against scoreboard.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ($countones(bus.o_req_ready) > 1) begin
      fails++;
      $display("FAIL ready_onehot actual=%b", bus.o_req_ready);
    end
    if (bus.o_rsp_valid != '0) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected valid=%b data=%h cyc=%0d",
                 bus.o_rsp_valid, bus.o_rsp_data, cyc);
      end else begin
        e = q.pop_front();
        if (bus.o_rsp_valid != (N'(1) << e.idx) ||
            bus.o_rsp_data != e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL rsp actual v=%b d=%h c=%0d required v=%b d=%h c=%0d",
                   bus.o_rsp_valid, bus.o_rsp_data, cyc,
                   N'(1) << e.idx, e.data, e.cyc);
        end
      end
    end
  end

  task automatic set_req(int k, bit we, int addr,
                         logic [W-1:0] data, logic [3:0] be);
    bus.i_req_valid[k]     = 1'b1;
    bus.i_req_we[k]        = we;
    bus.i_req_word_addr[k] = 3'(addr);
    bus.i_req_data[k]      = data;
    bus.i_req_byte_en[k]   = be;
  endtask

  task automatic push(int k, logic [W-1:0] d);
    q.push_back(exp_t'{idx: k, data: d, cyc: cyc + LAT + 1});
  endtask

  task automatic do_req(int k, bit we, int addr, logic [W-1:0] data,
                        logic [3:0] be, logic [W-1:0] exp_d);
    int n = 0;
    set_req(k, we, addr, data, be);
    @(negedge clk);
    while (!bus.o_req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.o_req_ready[k]) begin
      fails++;
      $display("FAIL grant_timeout req=%0d actual=%b", k, bus.o_req_ready);
      bus.i_req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.i_req_valid[k] = 1'b0;
    if (!we) push(k, exp_d);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, bus.o_req_ready, 0);
    chk({tag, "_rspv"}, bus.o_rsp_valid, 0);
    chk({tag, "_rspd"}, bus.o_rsp_data, 0);
    chk({tag, "_we"}, bus.o_ram_we, 0);
    chk({tag, "_addr"}, bus.o_ram_word_addr, 0);
    chk({tag, "_wdata"}, bus.o_ram_data, 0);
    chk({tag, "_be"}, bus.o_ram_wr_byte_en, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid     = '0;
    bus.i_req_we        = '0;
    bus.i_req_word_addr = '0;
    bus.i_req_data      = '0;
    bus.i_req_byte_en   = '0;
    #1;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    idle(1);

    // Fairness: both hold valid; grants alternate starting at req0.
    set_req(0, 1'b1, 0, 32'h0, 4'hF);
    set_req(1, 1'b1, 1, 32'h1, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fair%0d", i), bus.o_req_ready,
          (i % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      #1;
    end
    bus.i_req_valid = '0;

    // Single read after preload.
    do_req(0, 1'b1, 3, 32'hDEADBEEF, 4'hF, '0);
    do_req(0, 1'b0, 3, '0, 4'h0, 32'hDEADBEEF);
    idle(4);

    // Byte enables.
    do_req(0, 1'b1, 5, 32'h11223344, 4'hF, '0);
    do_req(0, 1'b1, 5, 32'hAABBCCDD, 4'b0101, '0);
    do_req(0, 1'b0, 5, '0, 4'h0, 32'h11BB33DD);
    idle(4);

    // Pipelined alternating reads; pointer last moved to req0.
    set_req(0, 1'b0, 0, '0, 4'h0);
    set_req(1, 1'b0, 1, '0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = (i % 2 == 0) ? 1 : 0;
      @(negedge clk);
      chk($sformatf("pipe_gnt%0d", i), bus.o_req_ready,
          (k == 0) ? 64'd1 : 64'd2);
      if (i > 0) chk($sformatf("pipe_busy%0d", i), bus.o_busy, 1);
      @(posedge clk);
      #1;
      push(k, W'(k));
    end
    bus.i_req_valid = '0;
    for (int j = 0; j <= LAT + 1; j++) begin
      if (j > 0) @(posedge clk);
      @(negedge clk);
      chk($sformatf("drain_busy%0d", j), bus.o_busy, (j <= LAT) ? 1 : 0);
    end
    idle(4);

    // Write then read of the same address on the next cycle.
    set_req(1, 1'b1, 7, 32'h5A5A5A5A, 4'hF);
    set_req(0, 1'b0, 7, '0, 4'h0);
    @(negedge clk);
    chk("haz_gnt1", bus.o_req_ready, 2);
    @(posedge clk);
    #1;
    bus.i_req_valid[1] = 1'b0;
    @(negedge clk);
    chk("haz_gnt0", bus.o_req_ready, 1);
    @(posedge clk);
    #1;
    bus.i_req_valid[0] = 1'b0;
    push(0, 32'h5A5A5A5A);
    idle(5);

    // Reset while a read is in flight: no response may follow.
    set_req(0, 1'b0, 3, '0, 4'h0);
    @(negedge clk);
    chk("mid_gnt", bus.o_req_ready, 1);
    @(posedge clk);
    #1;
    bus.i_req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    chk_zero("mid");
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    idle(5);

    // Pointer back at reset value: req0 wins first.
    set_req(0, 1'b0, 3, '0, 4'h0);
    set_req(1, 1'b0, 5, '0, 4'h0);
    @(negedge clk);
    chk("post_gnt0", bus.o_req_ready, 1);
    @(posedge clk);
    #1;
    bus.i_req_valid[0] = 1'b0;
    push(0, 32'hDEADBEEF);
    @(negedge clk);
    chk("post_gnt1", bus.o_req_ready, 2);
    @(posedge clk);
    #1;
    bus.i_req_valid[1] = 1'b0;
    push(1, 32'h11BB33DD);
    idle(6);

    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
